// File: rtl/spi_slave_ram_ctrl_if.sv
// SPI pin + RAM port bundle for spi_slave_ram_ctrl.
// slave: SS_n/MOSI/tx_* in, MISO/rx_* out; master: the mirror.
interface spi_slave_ram_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_ram_ctrl.sv
// SPI slave front end that turns MOSI frames into RAM command words
// and serialises RAM read data back on MISO.
// Ports: clk, rst_n (async, active low), bus (slave modport).
module spi_slave_ram_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_slave_ram_ctrl_if.slave   bus
);
    localparam int FW = ADDR_SIZE + 2;
    localparam int CW = $clog2(FW);
    localparam int TW = $clog2(ADDR_SIZE + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(ADDR_SIZE);
    localparam logic [CW-1:0] DONE     = CW'(ADDR_SIZE + 1);
    localparam logic [TW-1:0] TX_LAST  = TW'(ADDR_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [FW-2:0]         shreg;
    logic                  rd_addr_ok;
    logic                  tx_loaded;
    logic [TW-1:0]         tx_cnt;
    logic [ADDR_SIZE-1:0]  tx_shreg;
    logic [FW-1:0]         cmd_word;

    // Completed word on the last-bit edge, with the opcode LSB
    // overridden by the read path that was chosen.
    always_comb begin
        cmd_word = {shreg, bus.MOSI};
        if (state == READ_ADD) begin
            cmd_word[ADDR_SIZE] = 1'b0;
        end else if (state == READ_DATA) begin
            cmd_word[ADDR_SIZE] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            rd_addr_ok   <= 1'b0;
            tx_loaded    <= 1'b0;
            tx_cnt       <= '0;
            tx_shreg     <= '0;
            bus.MISO     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (state != IDLE && bus.SS_n) begin
                // Abort or end of frame: rd_addr_ok is left alone.
                state     <= IDLE;
                bit_cnt   <= '0;
                tx_cnt    <= '0;
                tx_loaded <= 1'b0;
                bus.MISO  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!bus.SS_n) begin
                            state <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        shreg   <= {{(FW-2){1'b0}}, bus.MOSI};
                        bit_cnt <= '0;
                        if (!bus.MOSI) begin
                            state <= WRITE;
                        end else if (rd_addr_ok) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt != DONE) begin
                            shreg   <= {shreg[FW-3:0], bus.MOSI};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                bus.rx_data  <= cmd_word;
                                bus.rx_valid <= 1'b1;
                                if (state == READ_ADD) begin
                                    rd_addr_ok <= 1'b1;
                                end
                            end
                        end else if (state == READ_DATA) begin
                            // First tx_valid loads the shifter and
                            // puts the MSB out on the same edge.
                            if (!tx_loaded) begin
                                if (bus.tx_valid) begin
                                    tx_loaded <= 1'b1;
                                    bus.MISO  <= bus.tx_data[ADDR_SIZE-1];
                                    tx_shreg  <= {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
                                    tx_cnt    <= TW'(1);
                                end
                            end else if (tx_cnt != TX_LAST) begin
                                bus.MISO <= tx_shreg[ADDR_SIZE-1];
                                tx_shreg <= {tx_shreg[ADDR_SIZE-2:0], 1'b0};
                                tx_cnt   <= tx_cnt + 1'b1;
                            end else begin
                                bus.MISO   <= 1'b0;
                                rd_addr_ok <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ram_ctrl.sv
// Bench for spi_slave_ram_ctrl: frame table, RAM responder,
// rx_data scoreboard and hand-written abort/reset sequences.
module tb_spi_slave_ram_ctrl;
    logic clk;
    logic rst_n;

    spi_slave_ram_ctrl_if #(.ADDR_SIZE(8)) bus ();

    spi_slave_ram_ctrl #(.ADDR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];

    // Behavioural single-port RAM answering the command words.
    logic [7:0] mem [256];
    logic [7:0] waddr;
    logic [7:0] raddr;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
        end else begin
            bus.tx_valid <= 1'b0;
            if (bus.rx_valid) begin
                case (bus.rx_data[9:8])
                    2'b00: waddr <= bus.rx_data[7:0];
                    2'b01: mem[waddr] <= bus.rx_data[7:0];
                    2'b10: raddr <= bus.rx_data[7:0];
                    default: begin
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= mem[raddr];
                    end
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rx_valid pops one expected word.
    always @(negedge clk) begin
        if (rst_n && bus.rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_valid: got %0h expected none",
                         bus.rx_data);
            end else begin
                check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive_bits(input logic [9:0] f, input int n);
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.MOSI = f[9-i];
        end
    endtask

    task automatic run_frame(input logic [9:0] f, input logic [9:0] exp,
                             input logic rd, input logic [7:0] exp_byte);
        logic       pre, at, post;
        logic       quiet;
        logic [7:0] got;
        exp_q.push_back(exp);
        drive_bits(f, 10);
        pre = bus.rx_valid;
        @(negedge clk);
        at = bus.rx_valid;
        quiet = (bus.MISO === 1'b0);
        @(negedge clk);
        post = bus.rx_valid;
        quiet &= (bus.MISO === 1'b0);
        check("rx_valid_pulse", 32'({pre, at, post}), 32'b010);
        if (rd) begin
            check("miso_before_shift", 32'(quiet), 32'd1);
            for (int b = 7; b >= 0; b--) begin
                @(negedge clk);
                got[b] = bus.MISO;
            end
            check("miso_byte", 32'(got), 32'(exp_byte));
            @(negedge clk);
            check("miso_after_shift", 32'(bus.MISO), 32'd0);
        end else begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                quiet &= (bus.MISO === 1'b0);
            end
            check("miso_quiet", 32'(quiet), 32'd1);
        end
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [9:0] frame;
        logic [9:0] exp_rx;
        logic       rd;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [2:0] got3;
        logic       seen;

        vt[0] = '{10'b00_0000_0101, 10'h005, 1'b0, 8'h00};
        vt[1] = '{10'b01_1010_0101, 10'h1A5, 1'b0, 8'h00};
        vt[2] = '{10'b11_0000_0101, 10'h205, 1'b0, 8'h00};
        vt[3] = '{10'b10_1111_0000, 10'h3F0, 1'b1, 8'hA5};
        vt[4] = '{10'b11_0000_0011, 10'h203, 1'b0, 8'h00};
        vt[5] = '{10'b00_0000_0011, 10'h003, 1'b0, 8'h00};
        vt[6] = '{10'b01_0011_1100, 10'h13C, 1'b0, 8'h00};
        vt[7] = '{10'b10_0000_0000, 10'h300, 1'b1, 8'h3C};

        rst_n    = 1'b0;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_miso", 32'(bus.MISO), 32'd0);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(vt[i].frame, vt[i].exp_rx, vt[i].rd, vt[i].exp_byte);
        end

        // Write frame aborted after five bits.
        drive_bits(10'b00_0000_0111, 5);
        @(negedge clk);
        bus.SS_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen |= (bus.rx_valid === 1'b1);
        end
        check("abort_no_rx_valid", 32'(seen), 32'd0);
        run_frame(10'b00_0000_1000, 10'h008, 1'b0, 8'h00);

        // Read-back aborted after three MISO bits, then retried.
        run_frame(10'b10_0000_0101, 10'h205, 1'b0, 8'h00);
        exp_q.push_back(10'h300);
        drive_bits(10'b11_0000_0000, 10);
        @(negedge clk);
        @(negedge clk);
        for (int b = 2; b >= 0; b--) begin
            @(negedge clk);
            got3[b] = bus.MISO;
        end
        check("abort_read_bits", 32'(got3), 32'b101);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check("abort_read_miso", 32'(bus.MISO), 32'd0);
        @(negedge clk);
        run_frame(10'b10_0000_0000, 10'h300, 1'b1, 8'hA5);

        // Reset in the middle of the MISO shift.
        run_frame(10'b10_0000_0101, 10'h205, 1'b0, 8'h00);
        exp_q.push_back(10'h3FF);
        drive_bits(10'b11_1111_1111, 10);
        repeat (4) @(negedge clk);
        check("pre_reset_miso", 32'(bus.MISO), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        bus.SS_n = 1'b1;
        @(negedge clk);
        run_frame(10'b11_0000_0101, 10'h205, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
